// File: rtl/score_keeper_pkg.sv
// Shared rhythm-game constants, key codes and game state encoding.
// Imported by the score keeper, its lane judges and their lane bus.
package rhythm_pkg;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_CLEAR = 8'h01;

    // D, F, J, K drive lanes 0..3 in the droppers
    localparam logic [7:0] KEY_LANE0 = 8'h07;
    localparam logic [7:0] KEY_LANE1 = 8'h09;
    localparam logic [7:0] KEY_LANE2 = 8'h0D;
    localparam logic [7:0] KEY_LANE3 = 8'h0E;

    localparam int unsigned Y_MAX   = 400;
    localparam int unsigned ARROW_H = 40;
    localparam int unsigned DROP_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } game_state_t;

    function automatic logic [DROP_W:0] drop_bottom(
        input logic [DROP_W-1:0] y
    );
        return {1'b0, y} + (DROP_W + 1)'(ARROW_H);
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Per-lane bus between the score keeper and one lane judge.
// Keeper (master) supplies lane inputs and phase; judge answers.
interface score_keeper_if;

    logic       clr;
    logic       en;
    logic       score_bit;
    logic [9:0] drop_y;
    logic       hit;
    logic       miss;
    logic       resolved;

    modport master (
        output clr,
        output en,
        output score_bit,
        output drop_y,
        input  hit,
        input  miss,
        input  resolved
    );

    modport slave (
        input  clr,
        input  en,
        input  score_bit,
        input  drop_y,
        output hit,
        output miss,
        output resolved
    );

endinterface

// File: rtl/score_lane_judge.sv
// One lane's hit/miss judge: edge-detects the held score flag and
// watches the arrow bottom, resolving the lane once per round.
module score_lane_judge
    import rhythm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    score_keeper_if.slave  lane
);

    logic prev_q;
    logic prev_d;
    logic resolved_q;
    logic resolved_d;
    logic hit;
    logic miss;
    logic at_bottom;

    always_comb begin
        at_bottom = drop_bottom(lane.drop_y) >= (DROP_W + 1)'(Y_MAX);
        hit = lane.en & ~resolved_q
            & lane.score_bit & ~prev_q;
        miss = lane.en & ~resolved_q & ~hit
             & ~lane.score_bit & at_bottom;
        // prev tracks every frame so a flag held before PLAY is no edge
        prev_d = lane.score_bit;
        resolved_d = lane.clr ? 1'b0
                   : (resolved_q | hit | miss);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b0;
            resolved_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            resolved_q <= resolved_d;
        end
    end

    assign lane.hit      = hit;
    assign lane.miss     = miss;
    assign lane.resolved = resolved_q;

endmodule

// File: rtl/score_keeper.sv
// Round FSM, combo/point arithmetic and HUD counters for the droppers.
// SCORE_KEEPER_BCD_EN adds a serial binary-to-BCD score_bcd output.
module score_keeper
    import rhythm_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int SCORE_W      = 12,
    parameter int CNT_W        = 4,
    parameter int HIT_POINTS   = 10,
    parameter int COMBO_THRESH = 2,
    parameter int COMBO_BONUS  = 5
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [7:0]              keycode,
    input  logic [7:0]              keycode_second,
    input  logic [NUM_LANES-1:0]    score_in,
    input  logic [NUM_LANES*10-1:0] dropY,
    output logic [SCORE_W-1:0]      total_score,
    output logic [CNT_W-1:0]        combo,
    output logic [CNT_W-1:0]        max_combo,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic                    round_done,
    output logic                    playing
`ifdef SCORE_KEEPER_BCD_EN
    ,
    output logic [15:0]             score_bcd
`endif
);

    localparam int PW = SCORE_W + 8;
    localparam int RW = CNT_W + 8;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_t state_q;
    game_state_t state_d;

    logic [SCORE_W-1:0] total_q;
    logic [SCORE_W-1:0] total_d;
    logic [CNT_W-1:0]   combo_q;
    logic [CNT_W-1:0]   combo_d;
    logic [CNT_W-1:0]   max_combo_q;
    logic [CNT_W-1:0]   max_combo_d;
    logic [CNT_W-1:0]   hit_count_q;
    logic [CNT_W-1:0]   hit_count_d;
    logic [CNT_W-1:0]   miss_count_q;
    logic [CNT_W-1:0]   miss_count_d;

    logic [NUM_LANES-1:0] hit_v;
    logic [NUM_LANES-1:0] miss_v;
    logic [NUM_LANES-1:0] res_v;

    logic key_space;
    logic key_clear;
    logic wipe;

    logic [PW-1:0]    pts;
    logic [PW-1:0]    total_sum;
    logic [RW-1:0]    run;
    logic [RW-1:0]    n_hit;
    logic [RW-1:0]    n_miss;
    logic [CNT_W-1:0] run_sat;

    function automatic logic [CNT_W-1:0] sat_cnt(
        input logic [RW-1:0] v
    );
        return (v > RW'(CNT_MAX)) ? CNT_MAX : v[CNT_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        score_keeper_if u_bus ();

        assign u_bus.clr       = (state_q == IDLE);
        assign u_bus.en        = (state_q == PLAY);
        assign u_bus.score_bit = score_in[i];
        assign u_bus.drop_y    = dropY[10*i +: 10];

        score_lane_judge u_judge (
            .clk  (frame_clk),
            .rst  (Reset),
            .lane (u_bus)
        );

        assign hit_v[i]  = u_bus.hit;
        assign miss_v[i] = u_bus.miss;
        assign res_v[i]  = u_bus.resolved;
    end

    assign key_space = (keycode == KEY_SPACE)
                     | (keycode_second == KEY_SPACE);
    assign key_clear = (keycode == KEY_CLEAR)
                     | (keycode_second == KEY_CLEAR);

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        combo_d      = combo_q;
        max_combo_d  = max_combo_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wipe         = 1'b0;
        pts          = '0;
        run          = RW'(combo_q);
        n_hit        = '0;
        n_miss       = '0;

        // hits in ascending lane order; each one bumps the running combo
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit_v[i]) begin
                pts = pts + PW'(HIT_POINTS);
                if (run >= RW'(COMBO_THRESH))
                    pts = pts + PW'(COMBO_BONUS);
                run   = run + RW'(1);
                n_hit = n_hit + RW'(1);
            end
            if (miss_v[i])
                n_miss = n_miss + RW'(1);
        end

        total_sum = PW'(total_q) + pts;
        run_sat   = sat_cnt(run);

        unique case (state_q)
            IDLE: begin
                wipe = 1'b1;
                if (key_space)
                    state_d = PLAY;
            end
            PLAY: begin
                if (key_clear) begin
                    state_d = IDLE;
                    wipe    = 1'b1;
                end else begin
                    total_d = (total_sum > PW'(SCORE_MAX))
                            ? SCORE_MAX
                            : total_sum[SCORE_W-1:0];
                    combo_d = (n_miss != '0) ? '0 : run_sat;
                    max_combo_d = (run_sat > max_combo_q)
                                ? run_sat : max_combo_q;
                    hit_count_d = sat_cnt(
                        RW'(hit_count_q) + n_hit);
                    miss_count_d = sat_cnt(
                        RW'(miss_count_q) + n_miss);
                    if (&(res_v | hit_v | miss_v))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (key_clear) begin
                    state_d = IDLE;
                    wipe    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wipe    = 1'b1;
            end
        endcase

        if (wipe) begin
            total_d      = '0;
            combo_d      = '0;
            max_combo_d  = '0;
            hit_count_d  = '0;
            miss_count_d = '0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            total_q      <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            combo_q      <= combo_d;
            max_combo_q  <= max_combo_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign total_score = total_q;
    assign combo       = combo_q;
    assign max_combo   = max_combo_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;
    assign round_done  = (state_q == DONE);
    assign playing     = (state_q == PLAY);

`ifdef SCORE_KEEPER_BCD_EN
    localparam int BW = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_q;
    logic [SCORE_W-1:0] bin_d;
    logic [SCORE_W-1:0] last_q;
    logic [SCORE_W-1:0] last_d;
    logic [15:0]        bcd_q;
    logic [15:0]        bcd_d;
    logic [15:0]        out_q;
    logic [15:0]        out_d;
    logic [15:0]        adj;
    logic [BW-1:0]      bit_q;
    logic [BW-1:0]      bit_d;
    logic               busy_q;
    logic               busy_d;

    always_comb begin
        bin_d  = bin_q;
        last_d = last_q;
        bcd_d  = bcd_q;
        out_d  = out_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        adj    = bcd_q;
        for (int d = 0; d < 4; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        // any new total restarts the conversion from scratch
        if (total_q != last_q) begin
            last_d = total_q;
            bin_d  = (32'(total_q) > 9999)
                   ? SCORE_W'(9999) : total_q;
            bcd_d  = '0;
            bit_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[14:0], bin_q[SCORE_W-1]};
            bin_d = bin_q << 1;
            bit_d = bit_q + BW'(1);
            if (bit_q == BW'(SCORE_W - 1)) begin
                busy_d = 1'b0;
                out_d  = {adj[14:0], bin_q[SCORE_W-1]};
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            bin_q  <= '0;
            last_q <= '0;
            bcd_q  <= '0;
            out_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            last_q <= last_d;
            bcd_q  <= bcd_d;
            out_q  <= out_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
        end
    end

    assign score_bcd = out_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a per-frame vector table plus
// hand sequences for reset mid-round, secondary clear and mixed frames.
module tb_score_keeper;

    typedef struct {
        logic [7:0]  key;
        logic [3:0]  sc;
        logic [39:0] dy;
        int          tot;
        int          cmb;
        int          mx;
        int          hc;
        int          mc;
        int          done;
        int          play;
    } vec_t;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic [7:0]  keycode_second;
    logic [3:0]  score_in;
    logic [39:0] dropY;
    logic [11:0] total_score;
    logic [3:0]  combo;
    logic [3:0]  max_combo;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;
    logic        round_done;
    logic        playing;
`ifdef SCORE_KEEPER_BCD_EN
    logic [15:0] score_bcd;
`endif

    int checks   = 0;
    int failures = 0;

    vec_t tbl [14];

    score_keeper dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .score_in       (score_in),
        .dropY          (dropY),
        .total_score    (total_score),
        .combo          (combo),
        .max_combo      (max_combo),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .round_done     (round_done),
        .playing        (playing)
`ifdef SCORE_KEEPER_BCD_EN
        ,
        .score_bcd      (score_bcd)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [39:0] lane_y(
        input int lane, input logic [9:0] y
    );
        logic [39:0] r;
        r = '0;
        r[10*lane +: 10] = y;
        return r;
    endfunction

    function automatic vec_t mk(
        input logic [7:0] key, input logic [3:0] sc,
        input logic [39:0] dy,
        input int tot, input int cmb, input int mx,
        input int hc, input int mc,
        input int done, input int play
    );
        vec_t v;
        v.key = key;  v.sc = sc;   v.dy = dy;
        v.tot = tot;  v.cmb = cmb; v.mx = mx;
        v.hc = hc;    v.mc = mc;
        v.done = done; v.play = play;
        return v;
    endfunction

    task automatic chk(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d",
                     name, act, exp);
        end
    endtask

    task automatic chk_all(
        input string tag,
        input int tot, input int cmb, input int mx,
        input int hc, input int mc,
        input int done, input int play
    );
        chk({tag, " total"}, 32'(total_score), tot);
        chk({tag, " combo"}, 32'(combo), cmb);
        chk({tag, " max"}, 32'(max_combo), mx);
        chk({tag, " hits"}, 32'(hit_count), hc);
        chk({tag, " misses"}, 32'(miss_count), mc);
        chk({tag, " done"}, 32'(round_done), done);
        chk({tag, " playing"}, 32'(playing), play);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

`ifdef SCORE_KEEPER_BCD_EN
    task automatic wait_bcd(
        input string name, input logic [15:0] exp
    );
        int n;
        n = 0;
        while (score_bcd !== exp && n < 13) begin
            tick();
            n++;
        end
        chk(name, 32'(score_bcd), 32'(exp));
    endtask
`endif

    initial begin
        tbl[0]  = mk(8'h2C, 4'b0000, '0, 0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(8'h00, 4'b0001, '0, 10, 1, 1, 1, 0, 0, 1);
        tbl[2]  = mk(8'h00, 4'b0001, '0, 10, 1, 1, 1, 0, 0, 1);
        tbl[3]  = mk(8'h00, 4'b0011, '0, 20, 2, 2, 2, 0, 0, 1);
        tbl[4]  = mk(8'h00, 4'b0111, '0, 35, 3, 3, 3, 0, 0, 1);
        tbl[5]  = mk(8'h00, 4'b0000, lane_y(3, 10'd300),
                     35, 3, 3, 3, 0, 0, 1);
        tbl[6]  = mk(8'h00, 4'b0000, lane_y(3, 10'd359),
                     35, 3, 3, 3, 0, 0, 1);
        tbl[7]  = mk(8'h00, 4'b0000, lane_y(3, 10'd360),
                     35, 0, 3, 3, 1, 1, 0);
        tbl[8]  = mk(8'h00, 4'b1000, '0, 35, 0, 3, 3, 1, 1, 0);
        tbl[9]  = mk(8'h01, 4'b0010, '0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(8'h2C, 4'b0010, '0, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(8'h00, 4'b1010, '0, 10, 1, 1, 1, 0, 0, 1);
        tbl[12] = mk(8'h00, 4'b1111, '0, 35, 3, 3, 3, 0, 0, 1);
        tbl[13] = mk(8'h00, 4'b1101, lane_y(1, 10'd360),
                     35, 0, 3, 3, 1, 1, 0);

        Reset          = 1'b1;
        keycode        = 8'h00;
        keycode_second = 8'h00;
        score_in       = 4'b0000;
        dropY          = '0;
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            keycode  = tbl[i].key;
            score_in = tbl[i].sc;
            dropY    = tbl[i].dy;
            tick();
            chk_all($sformatf("row%0d", i),
                    tbl[i].tot, tbl[i].cmb, tbl[i].mx,
                    tbl[i].hc, tbl[i].mc,
                    tbl[i].done, tbl[i].play);
        end

        keycode  = 8'h00;
        score_in = 4'b0000;
        dropY    = '0;
`ifdef SCORE_KEEPER_BCD_EN
        wait_bcd("bcd35", 16'h0035);
`endif
        chk_all("done hold", 35, 0, 3, 3, 1, 1, 0);

        keycode_second = 8'h01;
        tick();
        chk_all("clr2", 0, 0, 0, 0, 0, 0, 0);
        keycode_second = 8'h00;

        keycode = 8'h2C;
        tick();
        chk("start2 playing", 32'(playing), 1);
        keycode  = 8'h00;
        score_in = 4'b0001;
        tick();
        score_in = 4'b0011;
        tick();
        chk_all("pre-rst", 20, 2, 2, 2, 0, 0, 1);

        Reset    = 1'b1;
        score_in = 4'b0111;
        tick();
        chk_all("mid-rst", 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        score_in = 4'b1111;
        dropY    = {4{10'd360}};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i),
                    0, 0, 0, 0, 0, 0, 0);
        end

        keycode  = 8'h2C;
        score_in = 4'b0000;
        dropY    = '0;
        tick();
        chk("start3 playing", 32'(playing), 1);
        keycode  = 8'h00;
        score_in = 4'b0001;
        dropY    = lane_y(1, 10'd360);
        tick();
        chk_all("hit+miss", 10, 0, 1, 1, 1, 0, 1);

        score_in = 4'b1001;
        dropY    = lane_y(2, 10'd400);
        tick();
        chk_all("last frame", 20, 0, 1, 2, 2, 1, 0);
`ifdef SCORE_KEEPER_BCD_EN
        score_in = 4'b0000;
        dropY    = '0;
        wait_bcd("bcd20", 16'h0020);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
